// File: rtl/fetch_aligner_if.sv
// Handshake bundle between the fetch aligner, instruction memory and decode.
// The master modport is the aligner's view; the slave modport is the environment's.
interface fetch_aligner_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_is_c;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  redirect, redirect_pc,
        output inst_valid, inst, inst_pc, inst_is_c,
        input  inst_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output redirect, redirect_pc,
        input  inst_valid, inst, inst_pc, inst_is_c,
        output inst_ready
    );
endinterface

// File: rtl/fetch_aligner.sv
// Instruction-fetch front end: fetches 32-bit words into a 3-halfword buffer and
// presents one aligned RV32C or 32-bit instruction per handshake.
module fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    fetch_aligner_if.master bus
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_WAIT, S_DISCARD} state_t;

    state_t           r_state, w_state_nxt;
    logic [2:0][15:0] r_buf, w_buf_nxt;
    logic [1:0]       r_count, w_count_nxt;
    logic [31:0]      r_pc, w_pc_nxt;
    logic [31:0]      r_fetch_addr, w_fetch_nxt;
    logic [31:0]      r_stale_addr, w_stale_nxt;
    logic             r_skip, w_skip_nxt;

    logic        w_is_c, w_valid, w_consume, w_take;
    logic [1:0]  w_consume_n, w_app_n, w_keep, w_count_upd;
    logic [31:0] w_app_word, w_target;
    logic [47:0] w_shifted, w_keep_mask, w_app_mask, w_buf_upd;

    assign w_is_c  = (r_buf[0][1:0] != 2'b11);
    assign w_valid = w_is_c ? (r_count != 2'd0) : (r_count >= 2'd2);

    // A redirect voids both the decode handshake and any memory data this cycle.
    assign w_consume   = w_valid && bus.inst_ready && !bus.redirect;
    assign w_take      = (r_state == S_FILL) && bus.imem_ack && !bus.redirect;
    assign w_consume_n = !w_consume ? 2'd0 : (w_is_c ? 2'd1 : 2'd2);
    assign w_app_n     = !w_take ? 2'd0 : (r_skip ? 2'd1 : 2'd2);
    assign w_app_word  = r_skip ? {16'h0000, bus.imem_rdata[31:16]} : bus.imem_rdata;
    assign w_keep      = r_count - w_consume_n;
    assign w_count_upd = w_keep + w_app_n;

    assign w_shifted   = r_buf >> {w_consume_n, 4'b0000};
    assign w_keep_mask = (48'h1 << {w_keep, 4'b0000}) - 48'h1;
    assign w_app_mask  = w_app_n[1] ? 48'h0000_FFFF_FFFF :
                         (w_app_n[0] ? 48'h0000_0000_FFFF : 48'h0);
    assign w_buf_upd   = (w_shifted & w_keep_mask)
                       | (({16'h0000, w_app_word} & w_app_mask) << {w_keep, 4'b0000});

    assign w_target = bus.redirect_pc & 32'hFFFF_FFFE;

    assign bus.imem_req   = (r_state == S_FILL) || (r_state == S_DISCARD);
    assign bus.imem_addr  = (r_state == S_DISCARD) ? r_stale_addr : r_fetch_addr;
    assign bus.inst_valid = w_valid;
    assign bus.inst       = w_is_c ? {16'h0000, r_buf[0]} : {r_buf[1], r_buf[0]};
    assign bus.inst_pc    = r_pc;
    assign bus.inst_is_c  = w_is_c;

    // NOTE: every next-state variable gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = w_buf_upd;
        w_count_nxt = w_count_upd;
        w_pc_nxt    = r_pc + {29'd0, w_consume_n, 1'b0};
        w_fetch_nxt = r_fetch_addr;
        w_stale_nxt = r_stale_addr;
        w_skip_nxt  = r_skip;

        if (bus.redirect) begin
            w_buf_nxt   = '0;
            w_count_nxt = 2'd0;
            w_pc_nxt    = w_target;
            w_skip_nxt  = w_target[1];
            w_fetch_nxt = {w_target[31:2], 2'b00};
            case (r_state)
                S_FILL: begin
                    if (bus.imem_ack) begin
                        w_state_nxt = S_FILL;
                    end else begin
                        w_state_nxt = S_DISCARD;
                        w_stale_nxt = r_fetch_addr;
                    end
                end
                S_DISCARD: w_state_nxt = S_DISCARD;
                default:   w_state_nxt = S_FILL;
            endcase
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_FILL;
                S_FILL: begin
                    if (bus.imem_ack) begin
                        w_fetch_nxt = r_fetch_addr + 32'd4;
                        w_skip_nxt  = 1'b0;
                        w_state_nxt = (w_count_upd <= 2'd1) ? S_FILL : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_count_upd <= 2'd1) w_state_nxt = S_FILL;
                end
                S_DISCARD: begin
                    if (bus.imem_ack) w_state_nxt = S_FILL;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    // NOTE: the halfword buffer is reset too, because inst/inst_is_c are driven straight from it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_buf        <= '0;
            r_count      <= 2'd0;
            r_pc         <= RESET_PC;
            r_fetch_addr <= {RESET_PC[31:2], 2'b00};
            r_stale_addr <= {RESET_PC[31:2], 2'b00};
            r_skip       <= RESET_PC[1];
        end else begin
            r_state      <= w_state_nxt;
            r_buf        <= w_buf_nxt;
            r_count      <= w_count_nxt;
            r_pc         <= w_pc_nxt;
            r_fetch_addr <= w_fetch_nxt;
            r_stale_addr <= w_stale_nxt;
            r_skip       <= w_skip_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_aligner.sv
// Bench for fetch_aligner: instruction-stream model walking a memory image,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_aligner;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_aligner_if bus();

    fetch_aligner #(.RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] mem [256];
    int          force_lat = -1;
    int          max_lat = 0;

    logic [31:0] acked_q[$];
    logic [31:0] hs_pc_q[$];
    logic [31:0] hs_inst_q[$];
    logic        hs_c_q[$];
    int          hs_cyc_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // The instruction that must appear at address a, read straight from the image.
    function automatic logic [31:0] exp_inst(input logic [31:0] a);
        logic [15:0] h0;
        h0 = hw_at(a);
        if (h0[1:0] != 2'b11) return {16'h0000, h0};
        return {hw_at(a + 32'd2), h0};
    endfunction

    always @(posedge clk) cyc++;

    // Memory responder: random or forced latency, address must hold until ack.
    int          lat;
    bit          pending = 1'b0;
    logic [31:0] pend_addr;
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.imem_ack = 1'b0;
            pending = 1'b0;
        end else if (bus.imem_req) begin
            if (!pending) begin
                pending = 1'b1;
                pend_addr = bus.imem_addr;
                lat = (force_lat >= 0) ? force_lat : $urandom_range(max_lat, 0);
                check("imem_addr_aligned", {30'd0, bus.imem_addr[1:0]}, 32'd0);
            end else begin
                check("imem_addr_stable", bus.imem_addr, pend_addr);
            end
            if (lat == 0) begin
                bus.imem_ack = 1'b1;
                bus.imem_rdata = mem[pend_addr[9:2]];
                acked_q.push_back(pend_addr);
                pending = 1'b0;
            end else begin
                bus.imem_ack = 1'b0;
                bus.imem_rdata = $urandom;
                lat--;
            end
        end else begin
            if (pending) check("imem_req_dropped", 32'd0, 32'd1);
            pending = 1'b0;
            bus.imem_ack = 1'b0;
        end
    end

    // Stream checker: every valid cycle must show the instruction at the model PC.
    logic [31:0] model_pc = RESET_PC;
    logic [31:0] chk_exp;
    bit          prev_redirect = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_pc, prev_inst;
    always @(negedge clk) begin
        if (!rst_n) begin
            model_pc = RESET_PC;
            prev_redirect = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_redirect) check("valid_after_redirect", {31'd0, bus.inst_valid}, 32'd0);
            if (prev_stall) begin
                check("hold_valid", {31'd0, bus.inst_valid}, 32'd1);
                check("hold_pc", bus.inst_pc, prev_pc);
                check("hold_inst", bus.inst, prev_inst);
            end
            if (bus.inst_valid) begin
                chk_exp = exp_inst(model_pc);
                check("model_pc", bus.inst_pc, model_pc);
                check("model_inst", bus.inst, chk_exp);
                check("model_is_c", {31'd0, bus.inst_is_c}, {31'd0, chk_exp[1:0] != 2'b11});
                if (bus.inst_ready && !bus.redirect) begin
                    hs_pc_q.push_back(bus.inst_pc);
                    hs_inst_q.push_back(bus.inst);
                    hs_c_q.push_back(bus.inst_is_c);
                    hs_cyc_q.push_back(cyc);
                    model_pc = model_pc + ((chk_exp[1:0] != 2'b11) ? 32'd2 : 32'd4);
                end
            end
            if (bus.redirect) model_pc = bus.redirect_pc & 32'hFFFF_FFFE;
            prev_redirect = bus.redirect;
            prev_stall = bus.inst_valid && !bus.inst_ready && !bus.redirect;
            prev_pc = bus.inst_pc;
            prev_inst = bus.inst;
        end
    end

    task automatic clear_logs();
        hs_pc_q.delete();
        hs_inst_q.delete();
        hs_c_q.delete();
        hs_cyc_q.delete();
        acked_q.delete();
    endtask

    task automatic reset_begin();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.redirect = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_end();
        clear_logs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic fill_mem(input logic [31:0] w);
        for (int i = 0; i < 256; i++) mem[i] = w;
    endtask

    // Waits for n handshakes within a cycle budget; returns whether they arrived.
    task automatic wait_hs(input int n, input int budget, input string name, output bit ok);
        int k;
        k = 0;
        while (hs_pc_q.size() < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        ok = (hs_pc_q.size() >= n);
        check(name, ok ? 32'(n) : 32'(hs_pc_q.size()), 32'(n));
    endtask

    task automatic check_hs(input int i, input logic [31:0] pc, input logic [31:0] ins, input logic c);
        check("hs_pc", hs_pc_q[i], pc);
        check("hs_inst", hs_inst_q[i], ins);
        check("hs_is_c", {31'd0, hs_c_q[i]}, {31'd0, c});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int k;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'd0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'd0;
        bus.inst_ready = 1'b1;

        // Asynchronous reset while a request is outstanding and the buffer is non-empty.
        fill_mem(32'h0001_0001);
        force_lat = 3;
        reset_end();
        k = 0;
        while (!(bus.imem_req && bus.inst_valid) && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("reach_req_with_data", {31'd0, bus.imem_req && bus.inst_valid}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
        check("rst_imem_addr", bus.imem_addr, 32'd0);
        check("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("rst_inst", bus.inst, 32'd0);
        check("rst_inst_pc", bus.inst_pc, 32'd0);
        check("rst_inst_is_c", {31'd0, bus.inst_is_c}, 32'd1);
        force_lat = 0;
        reset_end();
        #1;
        check("idle_cycle_req", {31'd0, bus.imem_req}, 32'd0);
        @(posedge clk);
        #1;
        check("second_cycle_req", {31'd0, bus.imem_req}, 32'd1);
        check("second_cycle_addr", bus.imem_addr, 32'd0);

        // Aligned 32-bit stream.
        reset_begin();
        fill_mem(32'h0000_0013);
        mem[0] = 32'h0010_0093;
        mem[1] = 32'h0020_0113;
        mem[2] = 32'h0030_8193;
        mem[3] = 32'h0041_8213;
        reset_end();
        wait_hs(4, 40, "wait_32bit", ok);
        if (ok) begin
            check_hs(0, 32'h0, 32'h0010_0093, 1'b0);
            check_hs(1, 32'h4, 32'h0020_0113, 1'b0);
            check_hs(2, 32'h8, 32'h0030_8193, 1'b0);
            check_hs(3, 32'hC, 32'h0041_8213, 1'b0);
        end

        // Mixed stream with a 32-bit instruction straddling a word boundary.
        reset_begin();
        fill_mem(32'h0001_0001);
        mem[0] = 32'h0513_4501;
        mem[1] = 32'h0001_0093;
        reset_end();
        wait_hs(3, 40, "wait_mixed", ok);
        if (ok) begin
            check_hs(0, 32'h0, 32'h0000_4501, 1'b1);
            check_hs(1, 32'h2, 32'h0093_0513, 1'b0);
            check_hs(2, 32'h6, 32'h0000_0001, 1'b1);
        end

        // Compressed stream sustains one handshake per cycle.
        reset_begin();
        fill_mem(32'h0001_0001);
        reset_end();
        wait_hs(20, 80, "wait_compressed", ok);
        if (ok) check("compressed_throughput", 32'(hs_cyc_q[19] - hs_cyc_q[3]), 32'd16);

        // Backpressure from reset, then release.
        reset_begin();
        bus.inst_ready = 1'b0;
        reset_end();
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        check("bp_valid", {31'd0, bus.inst_valid}, 32'd1);
        check("bp_inst", bus.inst, 32'h0000_0001);
        check("bp_pc", bus.inst_pc, 32'h0);
        check("bp_req_idle", {31'd0, bus.imem_req}, 32'd0);
        bus.inst_ready = 1'b1;
        wait_hs(6, 30, "wait_bp_release", ok);
        if (ok) for (int i = 0; i < 6; i++) check("bp_release_pc", hs_pc_q[i], 32'(2 * i));

        // Redirect while a slow request is outstanding.
        reset_begin();
        mem[32'h100 >> 2] = 32'h4505_4501;
        force_lat = 3;
        reset_end();
        k = 0;
        while (!bus.imem_req && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("first_req_seen", {31'd0, bus.imem_req}, 32'd1);
        clear_logs();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0000_0102;
        @(posedge clk);
        #1;
        bus.redirect = 1'b0;
        wait_hs(1, 60, "wait_discard", ok);
        if (ok && acked_q.size() >= 2) begin
            check("stale_addr_acked", acked_q[0], 32'h0);
            check("refetch_addr", acked_q[1], 32'h100);
            check_hs(0, 32'h102, 32'h0000_4505, 1'b1);
        end else begin
            check("discard_ack_count", 32'(acked_q.size()), 32'd2);
        end

        // Redirect coinciding with an accepted instruction.
        force_lat = -1;
        max_lat = 0;
        k = 0;
        while (!bus.inst_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("valid_before_redirect", {31'd0, bus.inst_valid}, 32'd1);
        clear_logs();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0000_0040;
        @(posedge clk);
        #1;
        bus.redirect = 1'b0;
        check("redirect_bubble", {31'd0, bus.inst_valid}, 32'd0);
        wait_hs(1, 20, "wait_redirect_hs", ok);
        if (ok) check_hs(0, 32'h40, 32'h0000_0001, 1'b1);

        // Randomized traffic against the stream model.
        reset_begin();
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        max_lat = 3;
        reset_end();
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            bus.inst_ready = ($urandom_range(9, 0) < 7);
            bus.redirect = ($urandom_range(39, 0) == 0);
            bus.redirect_pc = $urandom;
        end
        bus.redirect = 1'b0;
        bus.inst_ready = 1'b1;
        repeat (5) @(posedge clk);
        check("random_progress", {31'd0, hs_pc_q.size() > 300}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
